rggen_apb_field_initiator: RTL
==============================

Name: rggen_apb_field_initiator

Overview:
- Bus-side initiator for the register-field software access interface. Accepts APB transfers and converts each one into a single-cycle software access strobe set toward the bit-field instances: valid, read mask, write enable, write mask and write data.
- Collects the selected register's read data and completes the APB transfer.
- Sits between the APB fabric and a bank of up to REGISTERS registers built from bit fields.

Parameters:
- ADDRESS_WIDTH, 8, APB address width; register index = i_paddr[ADDRESS_WIDTH-1:log2(BUS_WIDTH/8)].
- BUS_WIDTH, 32, data width; must be a multiple of 8.
- REGISTERS, 4, number of registers; contiguous from offset 0.
- ERROR_STATUS, 1, drive o_pslverr on an out-of-range access when 1.
- DEFAULT_READ_DATA, 0, o_prdata value on an out-of-range read.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_psel  in  1  APB select
- i_penable  in  1  APB enable
- i_paddr  in  ADDRESS_WIDTH  APB byte address
- i_pwrite  in  1  1 = write
- i_pwdata  in  BUS_WIDTH  write data
- i_pstrb  in  BUS_WIDTH/8  byte strobes
- o_pready  out  1  transfer complete
- o_prdata  out  BUS_WIDTH  read data
- o_pslverr  out  1  transfer error
- o_sw_valid  out  REGISTERS  one-hot per-register access strobe
- o_sw_read_mask  out  BUS_WIDTH  all ones on reads, zero on writes
- o_sw_write_enable  out  1  active-high write indication
- o_sw_write_mask  out  BUS_WIDTH  byte strobes expanded, each bit replicated 8 times
- o_sw_write_data  out  BUS_WIDTH  registered copy of i_pwdata
- i_sw_read_data  in  REGISTERS*BUS_WIDTH  register r read data at slice [r*BUS_WIDTH +: BUS_WIDTH]

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; the clock is i_clk. All outputs reset to 0 and the FSM resets to IDLE.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - Waits for i_psel && i_penable. When seen, registers index, direction, write data and expanded mask.
  - In range: go to ACCESS.
  - Index >= REGISTERS: go directly to RESPOND with the error flag set.
- ACCESS (exactly 1 cycle):
  - o_sw_valid[index]=1; all other valid bits 0.
  - Read: o_sw_read_mask=all ones, o_sw_write_enable=0, o_sw_write_mask=0.
  - Write: o_sw_read_mask=0, o_sw_write_enable=1, o_sw_write_mask from pstrb.
  - On the closing edge, i_sw_read_data slice [index] is captured into o_prdata (reads only).
  - Next state RESPOND.
- RESPOND (exactly 1 cycle):
  - o_pready=1.
  - o_prdata holds captured data on reads, 0 on writes, DEFAULT_READ_DATA on an out-of-range read.
  - o_pslverr = error flag && ERROR_STATUS.
  - Next state IDLE.
- Latency: o_pready rises 2 cycles after the first access-phase cycle (1 cycle when out of range). The block never completes in the first access-phase cycle.
- Valid timing:
  - o_sw_valid is a single-cycle pulse per transfer; bit fields rely on this for read-clear actions and triggers.
  - It never re-asserts while i_psel/i_penable stay high in RESPOND.
  - In IDLE the cycle immediately after RESPOND ignores i_penable.
- Strobe outputs: all strobe outputs return to 0 outside ACCESS. o_sw_write_data may hold its last value.
- Write with i_pstrb=0: valid still pulses, write mask is 0 (no field update), no error.
- Read with nonzero i_pstrb: strobes are ignored.
- Address bits below the byte-lane offset are ignored; there is no misalignment error.
- Inputs during an active transfer: i_psel dropping mid-transfer (protocol violation) does not abort. The FSM runs to IDLE and no second pulse occurs.
- Reset mid-operation: FSM returns to IDLE immediately; o_sw_valid and o_pready drop asynchronously; no partial pulse is resumed.

Decomposition:
- Shared package rggen_initiator_pkg: FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2), a byte-strobe-to-bit-mask expansion function, and a log2 helper constant function.
- One sub-module: rggen_initiator_read_mux, a combinational REGISTERS-to-1 read-data selector indexed by the registered index.

Test Plan:
- Write: paddr=0x04, pwdata=0xA5A5_1234, pstrb=4'b0011 -> exactly one cycle with o_sw_valid=4'b0010, write_mask=0x0000_FFFF, write_enable=1; o_pready=1 two cycles later, pslverr=0.
- Read: paddr=0x08, i_sw_read_data reg2=0xDEAD_BEEF -> one cycle with valid=4'b0100, read_mask=0xFFFF_FFFF; RESPOND shows prdata=0xDEAD_BEEF, pready=1.
- Out-of-range read at paddr=0x10 (REGISTERS=4) -> no valid pulse; pready=1 one cycle after access phase; pslverr=1, prdata=0. Repeat with ERROR_STATUS=0 -> pslverr=0.
- Back-to-back read then write, with the master holding penable through RESPOND -> exactly two valid pulses total, never two in consecutive transfers' RESPOND cycles.
- Assert i_rst_n=0 during ACCESS -> o_sw_valid and o_pready are 0 in the same cycle; after release a new transfer completes normally with the single-pulse property.
- Write with pstrb=0 to reg1 -> valid=4'b0010 with write_mask=0; the connected field value is unchanged; pslverr=0.

Source files
------------

// File: rtl/rggen_initiator_pkg.sv
// rggen_initiator_pkg
//   Shared definitions for the APB register-field initiator:
//   - initiator_state_e : FSM state encoding (IDLE / ACCESS / RESPOND)
//   - clog2             : constant log2 helper for parameter arithmetic
//   - expand_strobe     : byte strobes -> bit mask (each strobe bit replicated 8 times)
package rggen_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } initiator_state_e;

  // Widest bus the strobe expansion supports; callers size-cast the result.
  localparam int MAX_BUS_WIDTH    = 1024;
  localparam int MAX_STROBE_WIDTH = MAX_BUS_WIDTH / 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic logic [MAX_BUS_WIDTH-1:0] expand_strobe(
    input logic [MAX_STROBE_WIDTH-1:0] strobe
  );
    logic [MAX_BUS_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STROBE_WIDTH; i++) begin
      mask[i*8 +: 8] = {8{strobe[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_initiator_read_mux.sv
// rggen_initiator_read_mux
//   Combinational REGISTERS-to-1 selector for register read data.
//   Ports:
//     index     in  INDEX_WIDTH          registered register index
//     read_data in  REGISTERS*BUS_WIDTH  flattened read data, register r at [r*BUS_WIDTH +: BUS_WIDTH]
//     data      out BUS_WIDTH            selected read data, zero when index is out of range
module rggen_initiator_read_mux
  import rggen_initiator_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int REGISTERS   = 4,
  parameter int INDEX_WIDTH = 6
)(
  input  logic [INDEX_WIDTH-1:0]         index,
  input  logic [REGISTERS*BUS_WIDTH-1:0] read_data,
  output logic [BUS_WIDTH-1:0]           data
);

  localparam int SEL_WIDTH = (REGISTERS > 1) ? clog2(REGISTERS) : 1;

  logic [BUS_WIDTH-1:0] slice_s [REGISTERS];
  logic [SEL_WIDTH-1:0] sel_s;
  logic                 in_range_s;

  for (genvar g = 0; g < REGISTERS; g++) begin : g_slice
    assign slice_s[g] = read_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Upper index bits take part only in the range test, so a stale
  // out-of-range index can never alias onto a real register.
  assign sel_s      = index[SEL_WIDTH-1:0];
  assign in_range_s = (int'(index) < REGISTERS);
  assign data       = in_range_s ? slice_s[sel_s] : '0;

endmodule

// File: rtl/rggen_apb_field_initiator.sv
// rggen_apb_field_initiator
//   Converts each APB transfer into one single-cycle software access strobe
//   set toward a bank of bit-field registers, then completes the transfer
//   with the selected register's read data.
//   Ports:
//     i_clk, i_rst_n             clock, asynchronous active-low reset
//     i_psel/i_penable/i_paddr/i_pwrite/i_pwdata/i_pstrb   APB request
//     o_pready/o_prdata/o_pslverr                          APB response
//     o_sw_valid        one-hot per-register access pulse (ACCESS only)
//     o_sw_read_mask    all ones on reads
//     o_sw_write_enable write indication
//     o_sw_write_mask   byte strobes expanded to bits
//     o_sw_write_data   registered copy of i_pwdata
//     i_sw_read_data    register read data, register r at [r*BUS_WIDTH +: BUS_WIDTH]
module rggen_apb_field_initiator
  import rggen_initiator_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH     = 8,
  parameter int                   BUS_WIDTH         = 32,
  parameter int                   REGISTERS         = 4,
  parameter bit                   ERROR_STATUS      = 1'b1,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic                           i_pwrite,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  output logic                           o_pready,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_pslverr,
  output logic [REGISTERS-1:0]           o_sw_valid,
  output logic [BUS_WIDTH-1:0]           o_sw_read_mask,
  output logic                           o_sw_write_enable,
  output logic [BUS_WIDTH-1:0]           o_sw_write_mask,
  output logic [BUS_WIDTH-1:0]           o_sw_write_data,
  input  logic [REGISTERS*BUS_WIDTH-1:0] i_sw_read_data
);

  localparam int LANE_LSB    = clog2(BUS_WIDTH / 8);
  localparam int INDEX_WIDTH = ADDRESS_WIDTH - LANE_LSB;

  initiator_state_e         state_r;
  logic [INDEX_WIDTH-1:0]   index_r;
  logic                     write_r;
  // Set for the IDLE cycle right after RESPOND so a master still holding
  // psel/penable cannot trigger a second access pulse.
  logic                     rearm_block_r;

  logic [INDEX_WIDTH-1:0]   addr_index_s;
  logic                     in_range_s;
  logic [REGISTERS-1:0]     onehot_s;
  logic [BUS_WIDTH-1:0]     strobe_mask_s;
  logic [BUS_WIDTH-1:0]     mux_data_s;

  // Byte-lane offset bits carry no meaning: no misalignment error exists.
  if (LANE_LSB > 0) begin : g_lane_offset
    logic addr_offset_unused_s;
    assign addr_offset_unused_s = ^i_paddr[LANE_LSB-1:0];
  end

  assign addr_index_s  = i_paddr[ADDRESS_WIDTH-1:LANE_LSB];
  assign in_range_s    = (int'(addr_index_s) < REGISTERS);
  assign strobe_mask_s = BUS_WIDTH'(expand_strobe(MAX_STROBE_WIDTH'(i_pstrb)));

  for (genvar g = 0; g < REGISTERS; g++) begin : g_onehot
    assign onehot_s[g] = (int'(addr_index_s) == g);
  end

  rggen_initiator_read_mux #(
    .BUS_WIDTH   (BUS_WIDTH),
    .REGISTERS   (REGISTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_read_mux (
    .index     (index_r),
    .read_data (i_sw_read_data),
    .data      (mux_data_s)
  );

  // Transfer FSM; every output is a flop so strobes are glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r           <= IDLE;
      index_r           <= '0;
      write_r           <= 1'b0;
      rearm_block_r     <= 1'b0;
      o_pready          <= 1'b0;
      o_prdata          <= '0;
      o_pslverr         <= 1'b0;
      o_sw_valid        <= '0;
      o_sw_read_mask    <= '0;
      o_sw_write_enable <= 1'b0;
      o_sw_write_mask   <= '0;
      o_sw_write_data   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          rearm_block_r <= 1'b0;
          o_pready      <= 1'b0;
          o_pslverr     <= 1'b0;
          o_prdata      <= '0;
          if (i_psel && i_penable && !rearm_block_r) begin
            index_r         <= addr_index_s;
            write_r         <= i_pwrite;
            o_sw_write_data <= i_pwdata;
            if (in_range_s) begin
              state_r           <= ACCESS;
              o_sw_valid        <= onehot_s;
              o_sw_read_mask    <= i_pwrite ? '0 : '1;
              o_sw_write_enable <= i_pwrite;
              o_sw_write_mask   <= i_pwrite ? strobe_mask_s : '0;
            end else begin
              // Out of range: skip the field access and answer at once.
              state_r   <= RESPOND;
              o_pready  <= 1'b1;
              o_pslverr <= ERROR_STATUS;
              o_prdata  <= i_pwrite ? '0 : DEFAULT_READ_DATA;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r           <= RESPOND;
          o_sw_valid        <= '0;
          o_sw_read_mask    <= '0;
          o_sw_write_enable <= 1'b0;
          o_sw_write_mask   <= '0;
          o_pready          <= 1'b1;
          o_pslverr         <= 1'b0;
          o_prdata          <= write_r ? '0 : mux_data_s;
        end
        RESPOND: begin
          state_r       <= IDLE;
          rearm_block_r <= 1'b1;
          o_pready      <= 1'b0;
          o_pslverr     <= 1'b0;
          o_prdata      <= '0;
        end
        default: begin
          state_r           <= IDLE;
          rearm_block_r     <= 1'b0;
          o_pready          <= 1'b0;
          o_pslverr         <= 1'b0;
          o_prdata          <= '0;
          o_sw_valid        <= '0;
          o_sw_read_mask    <= '0;
          o_sw_write_enable <= 1'b0;
          o_sw_write_mask   <= '0;
        end
      endcase
    end
  end

endmodule
